seq_divider: RTL and testbench

Multi-cycle unsigned integer divider for the 32-bit ALU: the inverse operation to the adder chain, built on repeated trial subtraction (restoring division), one quotient bit per clock. It accepts a dividend/divisor pair on a start pulse, computes for WIDTH cycles, and returns quotient and remainder with a one-cycle done pulse. It sits beside the combinational add/sub datapath as the ALU's long-latency DIV/MOD unit.

---
 rtl/seq_divider.sv | 126 ++++++++++++
 tb/tb_seq_divider.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rstN            - rising-edge clock, async active-low reset
//   start                - request, sampled only when not busy (IDLE or DONE)
//   dividend, divisor    - operands, captured on an accepted start
//   quotient, remainder  - registered results, held until the next completion
//   busy                 - high while iterating
//   done                 - one-cycle pulse when results become valid
//   divByZero            - set with done when divisor was zero, held with results
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             divByZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Partial remainder is always < divisor, so its top (WIDTH+1-th) bit is
  // always zero between iterations and need not be stored.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    r_shift = {rem_q, quo_q[WIDTH-1]};
    // Trial subtraction as add of inverted divisor with carry-in; bit WIDTH is the sign.
    trial   = r_shift + ~{1'b0, dvs_q} + {{WIDTH{1'b0}}, 1'b1};

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dvs_d = divisor;
          rem_d = '0;
          quo_d = dividend;
          cnt_d = '0;
          if (divisor == '0) begin
            // Results are decided immediately; no iteration needed.
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = r_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          quotient_d  = quo_d;
          remainder_d = rem_d;
          dbz_d       = 1'b0;
          cnt_d       = '0;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign divByZero = dbz_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, divByZero;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rstN(rstN), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   e0 = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    chk("busy_done_exclusive", {31'b0, busy & done}, '0);
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("divByZero", {31'b0, divByZero}, {31'b0, e.z});
      end
    end
  end

  // Drive a request on the next cycle; returns positioned #1 after accept edge E0.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic z, input bit push);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b;
    if (push) begin
      e.q = q; e.r = r; e.z = z;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  // Waits for done, checking busy on the way and the latency relative to e0.
  task automatic wait_done(input int lat);
    int n = 0;
    if (lat == 0) chk("busy_never_div0", {31'b0, busy}, '0);
    while (!done && n < 200) begin
      chk("busy_while_run", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    chk("latency", cyc - e0, lat);
  endtask

  task automatic after_done();
    @(posedge clk); #1;
    chk("done_falls", {31'b0, done}, '0);
    chk("idle_not_busy", {31'b0, busy}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    logic [W-1:0] ra, rb;

    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1] = '{32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
    tbl[2] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    tbl[3] = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
    tbl[4] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    tbl[5] = '{32'd0,          32'd3,          32'd0,          32'd0,          1'b0};
    tbl[6] = '{32'd1000,       32'd10,         32'd100,        32'd0,          1'b0};
    tbl[7] = '{32'h80000000,   32'd3,          32'd715827882,  32'd2,          1'b0};
    tbl[8] = '{32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF,          1'b0};
    tbl[9] = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient", quotient, '0);
    chk("rst_remainder", remainder, '0);
    chk("rst_busy", {31'b0, busy}, '0);
    chk("rst_done", {31'b0, done}, '0);
    chk("rst_dbz", {31'b0, divByZero}, '0);
    rstN = 1'b1;

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, 1'b1);
      wait_done(tbl[i].b == '0 ? 0 : W);
      after_done();
    end

    // A few random operands checked against the bench's own / and %
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 32'h0000FFFF);
      if (i == 3) rb = $urandom | 32'h80000000;
      issue(ra, rb, ra / rb, ra % rb, 1'b0, 1'b1);
      wait_done(W);
      after_done();
    end

    // start while busy is ignored; exactly one done
    dc = done_cnt;
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(W);
    after_done();
    repeat (40) @(posedge clk);
    #1;
    chk("single_done_pulse", done_cnt - dc, 1);

    // Reset mid-run aborts; outputs clear immediately, no done follows
    dc = done_cnt;
    issue(32'd100, 32'd7, '0, '0, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    chk("midrun_busy", {31'b0, busy}, 32'd1);
    rstN = 1'b0;
    #1;
    chk("arst_quotient", quotient, '0);
    chk("arst_remainder", remainder, '0);
    chk("arst_busy", {31'b0, busy}, '0);
    chk("arst_done", {31'b0, done}, '0);
    chk("arst_dbz", {31'b0, divByZero}, '0);
    @(posedge clk); #1;
    rstN = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt - dc, 0);
    issue(32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 1'b1);
    wait_done(W);
    after_done();

    // Back-to-back: start held high, second op accepted in the DONE cycle
    begin
      exp_t e;
      @(posedge clk); #1;
      start = 1'b1; dividend = 32'd200; divisor = 32'd10;
      e.q = 32'd20; e.r = 32'd0; e.z = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      e0 = cyc;
      wait_done(W);
      dividend = 32'd201;
      e.q = 32'd20; e.r = 32'd1; e.z = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      e0 = cyc;
      chk("b2b_done_low", {31'b0, done}, '0);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(W);
      after_done();
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
